// File: rtl/mem_demux_2.sv
// mem_demux_2: single-outstanding request router to a memory target (0) or MMIO target (1) with response timeout.
module mem_demux_2 #(
  parameter int DEMUX_2_WIDTH = 32,
  parameter logic [3:0] MMIO_TAG = 4'hF,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [31:0]              i_addr,
  input  logic                     i_we,
  input  logic [DEMUX_2_WIDTH-1:0] i_wdata,
  output logic                     i_rvalid,
  output logic [DEMUX_2_WIDTH-1:0] i_rdata,
  output logic                     i_err,
  output logic                     t0_valid,
  output logic [31:0]              t0_addr,
  output logic                     t0_we,
  output logic [DEMUX_2_WIDTH-1:0] t0_wdata,
  input  logic                     t0_ready,
  input  logic                     t0_rvalid,
  input  logic [DEMUX_2_WIDTH-1:0] t0_rdata,
  output logic                     t1_valid,
  output logic [31:0]              t1_addr,
  output logic                     t1_we,
  output logic [DEMUX_2_WIDTH-1:0] t1_wdata,
  input  logic                     t1_ready,
  input  logic                     t1_rvalid,
  input  logic [DEMUX_2_WIDTH-1:0] t1_rdata
);
  localparam int TW = $clog2(TIMEOUT + 1) < 4 ? 4 : $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic sel, we, acc, hit, tmo, t_ready, t_rvalid;
  logic [31:0] addr;
  logic [DEMUX_2_WIDTH-1:0] wdata, t_rdata;
  logic [TW-1:0] timer;
  assign t_ready  = sel ? t1_ready : t0_ready;
  assign t_rvalid = sel ? t1_rvalid : t0_rvalid;
  assign t_rdata  = sel ? t1_rdata : t0_rdata;
  assign i_ready  = state == IDLE && !i_rvalid && !rst;
  assign acc      = i_valid && i_ready;
  assign hit      = state == WAIT && t_rvalid;
  assign tmo      = state != IDLE && timer == TW'(TIMEOUT) && !hit;
  assign t0_valid = state == ISSUE && !sel;
  assign t1_valid = state == ISSUE && sel;
  assign t0_addr  = addr;
  assign t1_addr  = addr;
  assign t0_we    = we;
  assign t1_we    = we;
  assign t0_wdata = wdata;
  assign t1_wdata = wdata;
  // timeout takes priority over a late ready so the request is withdrawn
  always_comb begin
    state_n = state;
    state_n = acc ? ISSUE : (hit || tmo) ? IDLE : (state == ISSUE && t_ready) ? WAIT : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= '0;
      addr     <= '0;
      we       <= 1'b0;
      wdata    <= '0;
      sel      <= 1'b0;
      timer    <= '0;
    end else begin
      state    <= state_n;
      i_rvalid <= hit || tmo;
      i_err    <= tmo;
      i_rdata  <= (hit && !we) ? t_rdata : '0;
      if (acc) begin
        addr  <= i_addr;
        we    <= i_we;
        wdata <= i_wdata;
        sel   <= i_addr[31:28] == MMIO_TAG;
        timer <= '0;
      end else if (state != IDLE) begin
        timer <= timer + TW'(1);
      end
    end
  end
endmodule

// File: doc/mem_demux_2.md
MEM_DEMUX_2 -- requirements
Module: mem_demux_2

Interface
REQ-001 The block SHALL have parameter DEMUX_2_WIDTH, default 32, giving the data width of all wdata/rdata buses.
REQ-002 The block SHALL have parameter MMIO_TAG, default 4'hF, where an address with i_addr[31:28]==MMIO_TAG selects target 1 and any other address selects target 0.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, giving the cycles from accept without response before an error response.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port i_valid, input, 1 bit, initiator request valid.
REQ-007 The block SHALL have port i_ready, output, 1 bit, request accepted when i_valid && i_ready.
REQ-008 The block SHALL have port i_addr, input, 32 bits, request byte address.
REQ-009 The block SHALL have port i_we, input, 1 bit, 1=store, 0=load.
REQ-010 The block SHALL have port i_wdata, input, DEMUX_2_WIDTH bits, store data.
REQ-011 The block SHALL have port i_rvalid, output, 1 bit, single-cycle response strobe.
REQ-012 The block SHALL have port i_rdata, output, DEMUX_2_WIDTH bits, load data, valid with i_rvalid.
REQ-013 The block SHALL have port i_err, output, 1 bit, timeout flag, valid with i_rvalid.
REQ-014 For N=0,1, the block SHALL have ports tN_valid (out, 1), tN_addr (out, 32), tN_we (out, 1) and tN_wdata (out, DEMUX_2_WIDTH) as the target request, tN_ready (in, 1) as target accept, and tN_rvalid (in, 1) with tN_rdata (in, DEMUX_2_WIDTH) as the target response.

Function
REQ-015 The block SHALL implement FSM states IDLE, ISSUE and WAIT, with one outstanding transaction at most.
REQ-016 In IDLE, i_ready SHALL be 1; on i_valid, the block SHALL register addr/we/wdata and sel=(i_addr[31:28]==MMIO_TAG), clear the timer, and go to ISSUE.
REQ-017 In ISSUE and WAIT, i_ready SHALL be 0.
REQ-018 In ISSUE, t[sel]_valid SHALL be 1 with the registered fields, and t[!sel]_valid SHALL be 0; when t[sel]_ready=1 the block SHALL go to WAIT.
REQ-019 t[sel]_valid and its fields SHALL stay stable until t[sel]_ready is sampled high.
REQ-020 tN_addr/tN_we/tN_wdata SHALL drive the registered fields on both targets at all times; only tN_valid discriminates the selected target.
REQ-021 In WAIT, on t[sel]_rvalid=1 the block SHALL assert i_rvalid=1, i_err=0 and i_rdata=t[sel]_rdata on the next cycle for exactly one cycle, and go to IDLE.
REQ-022 For a store, i_rdata SHALL be 0.
REQ-023 The 4-bit-or-wider timer SHALL increment every cycle in ISSUE and WAIT; when timer==TIMEOUT with no response, the block SHALL assert i_rvalid=1, i_err=1 and i_rdata=0 for one cycle, drop tN_valid, and go to IDLE.
REQ-024 If rvalid and the timeout occur in the same cycle, rvalid SHALL win and i_err SHALL be 0.
REQ-025 rvalid from the unselected target, or any rvalid while in IDLE or ISSUE, SHALL be ignored.
REQ-026 Minimum latency SHALL be: accept at cycle 0, tN_valid at cycle 1, ready at cycle 1 moving the FSM to WAIT at cycle 2, rvalid at cycle 2, i_rvalid at cycle 3.
REQ-027 The block SHALL NOT accept a new request in the cycle i_rvalid is high; the next accept is at cycle 4 or later.

Reset
REQ-028 While rst=1 at a clock edge, the FSM SHALL go to IDLE, and i_rvalid, i_err, i_rdata, t0_valid, t1_valid, registered fields and timer SHALL all become 0.
REQ-029 i_ready SHALL be 0 while rst is asserted and 1 in the first cycle after deassertion.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction with no i_rvalid, and late target responses SHALL be ignored.

Verification
REQ-031 Load 0x0000_0010, t0 ready same cycle, rvalid with rdata 0xDEADBEEF one cycle later -> t1_valid never 1; i_rvalid=1, i_rdata=0xDEADBEEF, i_err=0 at cycle 3.
REQ-032 Store 0xF000_0004, wdata 0x5A -> only t1_valid=1 with t1_we=1, t1_wdata=0x5A; i_rvalid with i_rdata=0.
REQ-033 t0_ready held low 3 cycles -> t0_valid and fields stable all 3 cycles; i_ready=0 throughout.
REQ-034 Target never asserts rvalid -> i_rvalid=1, i_err=1, i_rdata=0 when timer==15; next request accepted normally.
REQ-035 t1_rvalid pulsed while sel=0, and rvalid coincident with timeout -> spurious pulse ignored; coincident case returns data with i_err=0.
REQ-036 rst pulsed during WAIT -> all outputs 0 and no i_rvalid; following request completes correctly.
